// File: rtl/register_file_scoreboard.sv
// Register file with per-register pending-write counters, writeback-to-read bypass, flush and stack-pointer init.
// Reads are combinational. Issue backpressure comes from issue_ready when a counter is saturated, on flush or during INIT.
module register_file_scoreboard #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_READ_PORTS = 2,
  parameter int PEND_WIDTH     = 2,
  parameter int BYPASS_EN      = 1,
  parameter int SP_REG         = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(64'hDEADBEEFDEADBEEF)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                stackptr,
  input  logic [NUM_READ_PORTS-1:0]            rd_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_valid,
  output logic                                 raw_dependency,
  input  logic                                 issue_valid,
  input  logic [ADDR_WIDTH-1:0]                issue_dest,
  output logic                                 issue_ready,
  input  logic                                 wb_valid,
  input  logic [ADDR_WIDTH-1:0]                wb_addr,
  input  logic [DATA_WIDTH-1:0]                wb_data,
  input  logic                                 flush,
  output logic                                 write_complete,
  output logic                                 wb_underflow,
  output logic                                 init_done
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] SP_IDX   = ADDR_WIDTH'(SP_REG);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q;
  logic                    init_done_q;
  logic                    write_complete_q;
  logic                    wb_underflow_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [PEND_WIDTH-1:0]   pend_q [NUM_REGS];
  logic [PEND_WIDTH-1:0]   pend_d [NUM_REGS];

  logic run;
  logic issue_acc;
  logic wb_acc;
  logic same_reg;
  logic underflow_hit;

  assign run         = (state_q == ST_RUN);
  assign issue_ready = run & ~flush &
                       ((issue_dest == '0) | (pend_q[issue_dest] != PEND_MAX));
  assign issue_acc   = issue_valid & issue_ready;
  assign wb_acc      = wb_valid & run;
  // An issue and a writeback to the same register cancel out on the counter.
  assign same_reg    = issue_acc & wb_acc & (issue_dest == wb_addr);
  assign underflow_hit = wb_acc & ~flush & ~same_reg & (wb_addr != '0) &
                         (pend_q[wb_addr] == '0);

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (!run) begin
      regs_d[SP_IDX] = stackptr;
    end else if (wb_acc && (wb_addr != '0)) begin
      regs_d[wb_addr] = wb_data;
    end
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) pend_d[i] = '0;
    end else if (!same_reg) begin
      if (issue_acc && (issue_dest != '0))
        pend_d[issue_dest] = pend_q[issue_dest] + PEND_WIDTH'(1);
      if (wb_acc && (wb_addr != '0) && (pend_q[wb_addr] != '0))
        pend_d[wb_addr] = pend_q[wb_addr] - PEND_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
        pend_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_INIT;
      init_done_q      <= 1'b0;
      write_complete_q <= 1'b0;
      wb_underflow_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_q          <= ST_RUN;
          init_done_q      <= 1'b1;
          write_complete_q <= 1'b0;
        end
        ST_RUN: begin
          write_complete_q <= wb_valid;
          if (underflow_hit) wb_underflow_q <= 1'b1;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign write_complete = write_complete_q;
  assign wb_underflow   = wb_underflow_q;
  assign init_done      = init_done_q;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] data;
    logic                  vld;

    assign ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Nothing reads as current until INIT has loaded the stack pointer.
    always_comb begin
      data = '0;
      vld  = 1'b0;
      if (ra == '0) begin
        vld = run;
      end else if (pend_q[ra] == '0) begin
        data = regs_q[ra];
        vld  = run;
      end else if ((BYPASS_EN != 0) && wb_acc && (wb_addr == ra) &&
                   (pend_q[ra] == PEND_WIDTH'(1))) begin
        data = wb_data;
        vld  = 1'b1;
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_valid[p] = vld;
  end

  assign raw_dependency = |(rd_en & ~rd_valid);

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: directed vector table, random traffic against a behavioural model, mid-run reset.
module tb_register_file_scoreboard;

  localparam logic [63:0] RV = 64'hDEADBEEFDEADBEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  stackptr;
  logic [1:0]   rd_en;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_valid;
  logic         raw_dependency;
  logic         issue_valid;
  logic [4:0]   issue_dest;
  logic         issue_ready;
  logic         wb_valid;
  logic [4:0]   wb_addr;
  logic [63:0]  wb_data;
  logic         flush;
  logic         write_complete;
  logic         wb_underflow;
  logic         init_done;

  always #5 clk = ~clk;

  register_file_scoreboard dut (
    .clk(clk), .reset(reset), .stackptr(stackptr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .raw_dependency(raw_dependency),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .write_complete(write_complete), .wb_underflow(wb_underflow), .init_done(init_done)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: register contents, outstanding-write counts, status flags.
  logic [63:0] m_regs [32];
  int          m_pend [32];
  bit          m_run, m_init_done, m_wc, m_uf;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = RV;
      m_pend[i] = 0;
    end
    m_run = 0; m_init_done = 0; m_wc = 0; m_uf = 0;
  endfunction

  function automatic bit m_ready();
    return m_run && !flush && (issue_dest == 0 || m_pend[issue_dest] != 3);
  endfunction

  function automatic void m_read(input logic [4:0] a, output logic [63:0] d, output logic v);
    d = 64'd0;
    v = 1'b0;
    if (a == 0) begin
      v = m_run;
    end else if (m_pend[a] == 0) begin
      d = m_regs[a];
      v = m_run;
    end else if (m_run && wb_valid && wb_addr == a && m_pend[a] == 1) begin
      d = wb_data;
      v = 1'b1;
    end
  endfunction

  function automatic void m_edge();
    bit ia, wa;
    if (!m_run) begin
      m_regs[2] = stackptr;
      m_run = 1; m_init_done = 1; m_wc = 0;
    end else begin
      ia = issue_valid && m_ready();
      wa = wb_valid;
      m_wc = wa;
      if (wa && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else if (!(ia && wa && issue_dest == wb_addr)) begin
        if (ia && issue_dest != 0) m_pend[issue_dest]++;
        if (wa && wb_addr != 0) begin
          if (m_pend[wb_addr] > 0) m_pend[wb_addr]--;
          else m_uf = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic pre_edge();
    logic [63:0] d;
    logic        v;
    logic        raw;
    raw = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_read(rd_addr[p*5 +: 5], d, v);
      chk($sformatf("rd_data%0d", p), rd_data[p*64 +: 64], d);
      chk($sformatf("rd_valid%0d", p), 64'(rd_valid[p]), 64'(v));
      raw = raw | (rd_en[p] & ~v);
    end
    chk("raw_dependency", 64'(raw_dependency), 64'(raw));
    chk("issue_ready", 64'(issue_ready), 64'(m_ready()));
  endtask

  task automatic post_regs();
    chk("write_complete", 64'(write_complete), 64'(m_wc));
    chk("wb_underflow", 64'(wb_underflow), 64'(m_uf));
    chk("init_done", 64'(init_done), 64'(m_init_done));
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_edge();
    #1;
    post_regs();
  endtask

  task automatic set_in(input logic iv, input logic [4:0] d, input logic wv, input logic [4:0] wa,
                        input logic [63:0] wd, input logic fl, input logic [1:0] en,
                        input logic [4:0] a0, input logic [4:0] a1);
    issue_valid = iv; issue_dest = d; wb_valid = wv; wb_addr = wa; wb_data = wd;
    flush = fl; rd_en = en; rd_addr = {a1, a0};
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  d;
    logic        wv;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        fl;
    logic [4:0]  ra;
    logic [63:0] e_data;
    logic        e_vld;
    logic        e_rdy;
    logic        e_raw;
    logic        e_wc;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic iv, input logic [4:0] d, input logic wv, input logic [4:0] wa,
                      input logic [63:0] wd, input logic fl, input logic [4:0] ra,
                      input logic [63:0] ed, input logic ev, input logic erdy, input logic eraw);
    vec_t v;
    v = '{iv, d, wv, wa, wd, fl, ra, ed, ev, erdy, eraw, wv};
    vecs.push_back(v);
  endtask

  initial begin
    //   iv d  wv wa wd       fl ra  e_data    vld rdy raw
    addv(1, 5, 0, 0, 64'h0,    0, 5, RV,       1, 1, 0);
    addv(0, 5, 0, 0, 64'h0,    0, 5, 64'h0,    0, 1, 1);
    addv(0, 5, 1, 5, 64'h1234, 0, 5, 64'h1234, 1, 1, 0);
    addv(0, 0, 0, 0, 64'h0,    0, 5, 64'h1234, 1, 1, 0);
    addv(1, 7, 0, 0, 64'h0,    0, 7, RV,       1, 1, 0);
    addv(1, 7, 0, 0, 64'h0,    0, 7, 64'h0,    0, 1, 1);
    addv(1, 7, 0, 0, 64'h0,    0, 7, 64'h0,    0, 1, 1);
    addv(0, 7, 0, 0, 64'h0,    0, 7, 64'h0,    0, 0, 1);
    addv(0, 8, 0, 0, 64'h0,    0, 8, RV,       1, 1, 0);
    addv(0, 7, 1, 7, 64'hA1,   0, 7, 64'h0,    0, 0, 1);
    addv(0, 7, 1, 7, 64'hA2,   0, 7, 64'h0,    0, 1, 1);
    addv(0, 7, 1, 7, 64'hA3,   0, 7, 64'hA3,   1, 1, 0);
    addv(0, 0, 0, 0, 64'h0,    0, 7, 64'hA3,   1, 1, 0);
    addv(1, 9, 0, 0, 64'h0,    0, 9, RV,       1, 1, 0);
    addv(1, 9, 1, 9, 64'h99,   0, 9, 64'h99,   1, 1, 0);
    addv(0, 9, 0, 0, 64'h0,    0, 9, 64'h0,    0, 1, 1);
    addv(0, 9, 1, 9, 64'h9A,   0, 9, 64'h9A,   1, 1, 0);
    addv(1, 3, 0, 0, 64'h0,    0, 3, RV,       1, 1, 0);
    addv(1, 4, 0, 0, 64'h0,    0, 3, 64'h0,    0, 1, 1);
    addv(1, 6, 0, 0, 64'h0,    1, 4, 64'h0,    0, 0, 1);
    addv(0, 6, 0, 0, 64'h0,    0, 6, RV,       1, 1, 0);
    addv(0, 0, 0, 0, 64'h0,    0, 3, RV,       1, 1, 0);
    addv(0, 0, 1, 3, 64'h33,   0, 3, RV,       1, 1, 0);
    addv(0, 0, 0, 0, 64'h0,    0, 3, 64'h33,   1, 1, 0);
    addv(0, 0, 1, 0, 64'hFF,   0, 0, 64'h0,    1, 1, 0);
    addv(1, 0, 0, 0, 64'h0,    0, 0, 64'h0,    1, 1, 0);
    addv(0, 0, 0, 0, 64'h0,    0, 0, 64'h0,    1, 1, 0);

    // Power-on reset and INIT.
    reset = 1'b1;
    stackptr = 64'h8000_0000;
    set_in(0, 0, 0, 0, 64'h0, 0, 2'b11, 5'd2, 5'd5);
    m_reset();
    #1;
    pre_edge();
    post_regs();
    chk("init_x2_data", rd_data[63:0], RV);
    chk("init_x2_valid", 64'(rd_valid[0]), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 pre_edge();
    edge_step();
    chk("post_init_done", 64'(init_done), 64'd1);
    chk("post_init_x2", rd_data[63:0], 64'h8000_0000);
    chk("post_init_x5", rd_data[127:64], RV);
    chk("post_init_valid", 64'(rd_valid), 64'd3);

    foreach (vecs[i]) begin
      set_in(vecs[i].iv, vecs[i].d, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].fl,
             2'b01, vecs[i].ra, 5'd4);
      #1;
      chk($sformatf("vec%0d_data", i), rd_data[63:0], vecs[i].e_data);
      chk($sformatf("vec%0d_valid", i), 64'(rd_valid[0]), 64'(vecs[i].e_vld));
      chk($sformatf("vec%0d_ready", i), 64'(issue_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_raw", i), 64'(raw_dependency), 64'(vecs[i].e_raw));
      pre_edge();
      edge_step();
      chk($sformatf("vec%0d_wc", i), 64'(write_complete), 64'(vecs[i].e_wc));
    end
    chk("underflow_sticky", 64'(wb_underflow), 64'd1);

    for (int n = 0; n < 1500; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
             1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)),
             {$urandom, $urandom}, 1'($urandom_range(0, 19) == 0),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      #1 pre_edge();
      edge_step();
    end

    // Asynchronous reset in the middle of a cycle with write_complete high.
    set_in(0, 0, 1, 5, 64'h55, 0, 2'b11, 5'd2, 5'd5);
    #1 pre_edge();
    edge_step();
    set_in(0, 0, 0, 0, 64'h0, 0, 2'b11, 5'd2, 5'd5);
    #1 chk("pre_reset_wc", 64'(write_complete), 64'd1);
    reset = 1'b1;
    m_reset();
    #1;
    pre_edge();
    post_regs();
    chk("async_wc", 64'(write_complete), 64'd0);
    chk("async_init_done", 64'(init_done), 64'd0);
    chk("async_underflow", 64'(wb_underflow), 64'd0);
    chk("async_x2_data", rd_data[63:0], RV);
    chk("async_rd_valid", 64'(rd_valid), 64'd0);
    chk("async_ready", 64'(issue_ready), 64'd0);
    stackptr = 64'h1000;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 pre_edge();
    edge_step();
    chk("reinit_x2", rd_data[63:0], 64'h1000);
    chk("reinit_x5", rd_data[127:64], RV);
    for (int n = 0; n < 200; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             {$urandom, $urandom}, 1'($urandom_range(0, 29) == 0),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1 pre_edge();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
